core_sequencer: RTL and testbench

// - Multi-cycle control FSM for the 16-bit core. Runs FETCH -> DECODE -> EXECUTE -> WRITEBACK for each instruction.
// - Owns the PC and the instruction register (IR). Drives the instruction-memory request and the decode, execute and write-back enables.
// - Feeds IR to the decode unit and holds it stable for the whole instruction.
// - Instruction fields: func3=[15:13], rs1=[12:10], rs2=[9:7], rd=[6:4], opcode=[3:0].

---
 rtl/core_pkg.sv | 29 ++
 rtl/core_sequencer.sv | 125 ++++++++++++
 tb/tb_core_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core control path: FSM state encoding,
// the halt opcode and the instruction field positions.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_STEP_WAIT = 3'd6
    } state_t;

    localparam logic [3:0] HALT_OP = 4'b1111;

    // Instruction layout: func3=[15:13] rs1=[12:10] rs2=[9:7] rd=[6:4] opcode=[3:0]
    localparam int FUNC3_LSB  = 13;
    localparam int FUNC3_W    = 3;
    localparam int RS1_LSB    = 10;
    localparam int RS1_W      = 3;
    localparam int RS2_LSB    = 7;
    localparam int RS2_W      = 3;
    localparam int RD_LSB     = 4;
    localparam int RD_W       = 3;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 4;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the 16-bit core: FETCH -> DECODE -> EXECUTE ->
// WRITEBACK per instruction. Owns PC, IR and the retired-instruction counter.
// Optional single-step mode is built when SEQ_STEP_EN is defined (adds the
// step input and the STEP_WAIT state).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | stopped at an instruction boundary, waiting for run
// S_FETCH     | imem_req high, waiting for imem_valid to load IR
// S_DECODE    | dec_en high for DEC_CYCLES cycles (down-counter)
// S_EXECUTE   | exe_en high until exe_done (inclusive)
// S_WRITEBACK | one-cycle wb_en strobe; PC and retired advance at its end
// S_HALT      | halt opcode decoded; only rst leaves
// S_STEP_WAIT | (SEQ_STEP_EN) waiting for step after each instruction
module core_sequencer
    import core_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              DEC_CYCLES  = 2,
    parameter logic [3:0]      HALT_OPCODE = HALT_OP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
`ifdef SEQ_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_ins,
    input  logic            imem_valid,
    output logic [15:0]     ir,
    output logic            dec_en,
    output logic            exe_en,
    input  logic            exe_done,
    output logic            wb_en,
    output logic [2:0]      wb_rd,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired,
    output logic            halted
);

    // Counter is loaded with DEC_CYCLES-1 on fetch accept; decode ends at zero.
    localparam logic [2:0] DEC_LOAD = 3'(DEC_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] dec_cnt;

    assign imem_addr = pc;
    assign wb_rd     = ir[RD_LSB +: RD_W];

    // State, PC, IR, decode counter and retired count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            retired <= '0;
            dec_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && imem_valid) begin
                ir      <= imem_ins;
                dec_cnt <= DEC_LOAD;
            end else if (state == S_DECODE && dec_cnt != 3'd0) begin
                dec_cnt <= dec_cnt - 3'd1;
            end
            if (state == S_WRITEBACK) begin
                pc      <= pc + PC_W'(1);
                retired <= retired + 16'd1;
            end
        end
    end

    // Next-state logic and Moore outputs decoded from the registered state.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dec_en    = 1'b0;
        exe_en    = 1'b0;
        wb_en     = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                dec_en = 1'b1;
                if (dec_cnt == 3'd0) begin
                    if (ir[OPCODE_LSB +: OPCODE_W] == HALT_OPCODE) state_nxt = S_HALT;
                    else                                           state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                exe_en = 1'b1;
                if (exe_done) state_nxt = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                wb_en = 1'b1;
`ifdef SEQ_STEP_EN
                state_nxt = S_STEP_WAIT;
`else
                state_nxt = run ? S_FETCH : S_IDLE;
`endif
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef SEQ_STEP_EN
            S_STEP_WAIT: begin
                if (!run)      state_nxt = S_IDLE;
                else if (step) state_nxt = S_FETCH;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. A per-cycle stimulus table drives reset, a
// single ALU instruction, a memory wait and a run drop; hand-written sequences
// then cover slow execute, run drop mid-execute, PC wrap, HALT and resets in
// the middle of fetch and execute. Each driven cycle pushes its expected
// outputs to a queue that is popped and compared on the falling edge.
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        imem_valid = 1'b0;
   logic        exe_done = 1'b0;
   logic [15:0] imem_ins = 16'h0;
`ifdef SEQ_STEP_EN
   logic        step = 1'b0;
`endif
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] ir;
   logic        dec_en;
   logic        exe_en;
   logic        wb_en;
   logic [2:0]  wb_rd;
   logic [7:0]  pc;
   logic [15:0] retired;
   logic        halted;

   core_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
`ifdef SEQ_STEP_EN
      .step       (step),
`endif
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ins   (imem_ins),
      .imem_valid (imem_valid),
      .ir         (ir),
      .dec_en     (dec_en),
      .exe_en     (exe_en),
      .exe_done   (exe_done),
      .wb_en      (wb_en),
      .wb_rd      (wb_rd),
      .pc         (pc),
      .retired    (retired),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        rst, run, step, valid;
      logic [15:0] ins;
      logic        done, chk;
      logic        req, dec, exe, wb, halted;
      logic [7:0]  pc;
      logic [15:0] ret, ir;
   } vec_t;

   vec_t        expq[$];
   vec_t        tbl[$];
   vec_t        ce;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  m_pc;
   logic [15:0] m_ret;
   logic [15:0] m_ir;

   function automatic vec_t mk(string nm, logic r, logic ru, logic st, logic va,
                               logic [15:0] ins, logic dn, logic chk,
                               logic rq, logic de, logic ex, logic wb, logic ha,
                               logic [7:0] p, logic [15:0] rt, logic [15:0] irv);
      vec_t v;
      v.nm = nm; v.rst = r; v.run = ru; v.step = st; v.valid = va;
      v.ins = ins; v.done = dn; v.chk = chk;
      v.req = rq; v.dec = de; v.exe = ex; v.wb = wb; v.halted = ha;
      v.pc = p; v.ret = rt; v.ir = irv;
      return v;
   endfunction

   // Cycle with rst low whose expected pc/retired/ir come from the bench model.
   function automatic vec_t mm(string nm, logic ru, logic st, logic va, logic [15:0] ins,
                               logic dn, logic rq, logic de, logic ex, logic wb, logic ha);
      return mk(nm, 1'b0, ru, st, va, ins, dn, 1'b1, rq, de, ex, wb, ha, m_pc, m_ret, m_ir);
   endfunction

   task automatic drive(input vec_t v);
      @(posedge clk);
      #1;
      rst        = v.rst;
      run        = v.run;
      imem_valid = v.valid;
      imem_ins   = v.ins;
      exe_done   = v.done;
`ifdef SEQ_STEP_EN
      step       = v.step;
`endif
      if (v.chk) expq.push_back(v);
   endtask

   // Direct check of the DUT outputs at the next falling edge.
   task automatic check_state(input string nm, input logic rq, input logic de,
                              input logic ex, input logic wb, input logic ha,
                              input logic [7:0] p, input logic [15:0] rt,
                              input logic [15:0] irv);
      @(negedge clk);
      #1;
      total++;
      if ({imem_req, dec_en, exe_en, wb_en, halted} !== {rq, de, ex, wb, ha}
          || pc !== p || imem_addr !== p || retired !== rt || ir !== irv) begin
         bad++;
         $display("FAIL %s: got req/dec/exe/wb/halt=%b pc=%h ret=%h ir=%h, want %b pc=%h ret=%h ir=%h",
                  nm, {imem_req, dec_en, exe_en, wb_en, halted}, pc, retired, ir,
                  {rq, de, ex, wb, ha}, p, rt, irv);
      end
   endtask

   // Runs one instruction starting in FETCH; stops after decode for a halt opcode.
   task automatic do_instr(input string nm, input logic [15:0] ins, input int mw,
                           input int ex, input logic drop);
      for (int i = 0; i < mw; i++)
         drive(mm({nm, "_wait"}, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(mm({nm, "_fetch"}, 1'b1, 1'b0, 1'b1, ins, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      m_ir = ins;
      for (int i = 0; i < 2; i++)
         drive(mm({nm, "_dec"}, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      if (ins[3:0] == 4'hF) return;
      for (int i = 0; i < ex; i++)
         drive(mm({nm, "_exe"}, !drop, 1'b0, 1'b0, 16'h0, (i == ex - 1),
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      drive(mm({nm, "_wb"}, !drop, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      m_pc  = m_pc + 8'd1;
      m_ret = m_ret + 16'd1;
`ifdef SEQ_STEP_EN
      if (drop) begin
         drive(mm({nm, "_stepw"}, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
         drive(mm({nm, "_hold"}, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         drive(mm({nm, "_hold"}, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         drive(mm({nm, "_step"}, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
`endif
   endtask

   // Scoreboard: compare the DUT against the expectation pushed for this cycle.
   always @(negedge clk) begin
      if (expq.size() != 0) begin
         ce = expq.pop_front();
         total++;
         if ({imem_req, dec_en, exe_en, wb_en, halted} !== {ce.req, ce.dec, ce.exe, ce.wb, ce.halted}
             || pc !== ce.pc || imem_addr !== ce.pc || retired !== ce.ret || ir !== ce.ir
             || (ce.wb && wb_rd !== ce.ir[6:4])) begin
            bad++;
            $display("FAIL %s: got req/dec/exe/wb/halt=%b pc=%h addr=%h ret=%h ir=%h rd=%0d, want %b pc=%h ret=%h ir=%h rd=%0d",
                     ce.nm, {imem_req, dec_en, exe_en, wb_en, halted}, pc, imem_addr, retired, ir, wb_rd,
                     {ce.req, ce.dec, ce.exe, ce.wb, ce.halted}, ce.pc, ce.ret, ce.ir, ce.ir[6:4]);
         end
      end
   end

   initial begin
      //                  name              rst run stp val ins     done chk req dec exe wb  hlt pc     ret     ir
      tbl.push_back(mk("rst_a",           1, 1, 0, 0, 16'h0,    0, 0,  0, 0, 0, 0, 0, 8'h00, 16'd0, 16'h0000));
      tbl.push_back(mk("rst_b",           1, 1, 0, 0, 16'h0,    0, 1,  0, 0, 0, 0, 0, 8'h00, 16'd0, 16'h0000));
      tbl.push_back(mk("idle_after_rst",  0, 1, 0, 0, 16'h0,    0, 1,  0, 0, 0, 0, 0, 8'h00, 16'd0, 16'h0000));
      tbl.push_back(mk("alu_fetch",       0, 1, 0, 1, 16'h2051, 0, 1,  1, 0, 0, 0, 0, 8'h00, 16'd0, 16'h0000));
      tbl.push_back(mk("alu_dec1",        0, 1, 0, 0, 16'h0,    0, 1,  0, 1, 0, 0, 0, 8'h00, 16'd0, 16'h2051));
      tbl.push_back(mk("alu_dec2",        0, 1, 0, 0, 16'h0,    0, 1,  0, 1, 0, 0, 0, 8'h00, 16'd0, 16'h2051));
      tbl.push_back(mk("alu_exe",         0, 1, 0, 0, 16'h0,    1, 1,  0, 0, 1, 0, 0, 8'h00, 16'd0, 16'h2051));
      tbl.push_back(mk("alu_wb",          0, 1, 0, 0, 16'h0,    0, 1,  0, 0, 0, 1, 0, 8'h00, 16'd0, 16'h2051));
`ifdef SEQ_STEP_EN
      tbl.push_back(mk("alu_stepw",       0, 1, 1, 0, 16'h0,    0, 1,  0, 0, 0, 0, 0, 8'h01, 16'd1, 16'h2051));
`endif
      tbl.push_back(mk("mw_wait1",        0, 1, 0, 0, 16'h0,    0, 1,  1, 0, 0, 0, 0, 8'h01, 16'd1, 16'h2051));
      tbl.push_back(mk("mw_wait2",        0, 1, 0, 0, 16'h0,    0, 1,  1, 0, 0, 0, 0, 8'h01, 16'd1, 16'h2051));
      tbl.push_back(mk("mw_wait3",        0, 1, 0, 0, 16'h0,    0, 1,  1, 0, 0, 0, 0, 8'h01, 16'd1, 16'h2051));
      tbl.push_back(mk("mw_accept",       0, 1, 0, 1, 16'h1234, 0, 1,  1, 0, 0, 0, 0, 8'h01, 16'd1, 16'h2051));
      tbl.push_back(mk("mw_dec1",         0, 1, 0, 0, 16'h0,    0, 1,  0, 1, 0, 0, 0, 8'h01, 16'd1, 16'h1234));
      tbl.push_back(mk("mw_dec2",         0, 1, 0, 0, 16'h0,    0, 1,  0, 1, 0, 0, 0, 8'h01, 16'd1, 16'h1234));
      tbl.push_back(mk("mw_exe",          0, 1, 0, 0, 16'h0,    1, 1,  0, 0, 1, 0, 0, 8'h01, 16'd1, 16'h1234));
      tbl.push_back(mk("mw_wb",           0, 0, 0, 0, 16'h0,    0, 1,  0, 0, 0, 1, 0, 8'h01, 16'd1, 16'h1234));
      tbl.push_back(mk("stop_idle1",      0, 0, 0, 0, 16'h0,    0, 1,  0, 0, 0, 0, 0, 8'h02, 16'd2, 16'h1234));
      tbl.push_back(mk("stop_idle2",      0, 0, 0, 1, 16'h0,    0, 1,  0, 0, 0, 0, 0, 8'h02, 16'd2, 16'h1234));
      tbl.push_back(mk("stop_idle3",      0, 1, 0, 0, 16'h0,    0, 1,  0, 0, 0, 0, 0, 8'h02, 16'd2, 16'h1234));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         if (tbl[i].nm == "rst_b")
            check_state("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 16'h0000);
         else if (tbl[i].nm == "mw_wait3")
            check_state("mem_wait_expired", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'd1, 16'h2051);
      end

      m_pc = 8'h02; m_ret = 16'd2; m_ir = 16'h1234;

      do_instr("slow", 16'h3062, 0, 5, 1'b0);
      do_instr("drop", 16'h0070, 0, 2, 1'b1);
      for (int i = 0; i < 3; i++)
         drive(mm("drop_idle", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(mm("resume", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int k = 0; k < 300 && m_pc != 8'hFF; k++)
         do_instr("walk", 16'h0041, k % 2, 1, 1'b0);
      do_instr("wrap", 16'h4020, 0, 1, 1'b0);

      do_instr("halt", 16'h000F, 1, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(mm("halt_hold", (i % 2 == 1), 1'b1, 1'b1, 16'h2051, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      drive(mk("halt_rst", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_pc, m_ret, m_ir));
      m_pc = 8'h00; m_ret = 16'd0; m_ir = 16'h0000;
      drive(mm("post_rst", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      drive(mm("mx_fetch", 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      m_ir = 16'h5555;
      for (int i = 0; i < 2; i++)
         drive(mm("mx_dec", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      drive(mm("mx_exe1", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      drive(mk("mx_exe_rst", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_pc, m_ret, m_ir));
      m_ir = 16'h0000;
      drive(mm("mx_after_rst", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(mk("mf_fetch_rst", 1'b1, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_ret, m_ir));
      drive(mm("mf_after_rst", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drive(mm("end_idle", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      check_state("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 16'h0000);

      @(negedge clk);
      #1;
      if (bad != 0 || total == 0)
         $display("FAIL summary: total=%0d bad=%0d", total, bad);
      else
         $display("PASS");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
